// File: rtl/wildcard_flow_matcher_if.sv
// Bundles the lookup, table-write and counter-read signals of the wildcard
// flow matcher. The master side is the requester (parser / control block),
// the slave side is the matcher itself.
interface wildcard_flow_matcher_if #(
    parameter int CMP_WIDTH  = 240,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
);
    // Lookup request / result
    logic                  lookup_req;
    logic [CMP_WIDTH-1:0]  lookup_cmp_data;
    logic                  lookup_ack;
    logic                  lookup_hit;
    logic [ADDR_WIDTH-1:0] lookup_address;
    logic [DATA_WIDTH-1:0] lookup_data;

    // Table write port
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  wr_valid;
    logic [CMP_WIDTH-1:0]  wr_cmp;
    logic [CMP_WIDTH-1:0]  wr_mask;
    logic [DATA_WIDTH-1:0] wr_data;

    // Counter read port and miss statistic
    logic                  ctr_rd_req;
    logic [ADDR_WIDTH-1:0] ctr_rd_addr;
    logic                  ctr_rd_ack;
    logic [CNT_WIDTH-1:0]  ctr_rd_data;
    logic [CNT_WIDTH-1:0]  miss_count;

    modport master (
        output lookup_req, lookup_cmp_data,
        output wr_req, wr_addr, wr_valid, wr_cmp, wr_mask, wr_data,
        output ctr_rd_req, ctr_rd_addr,
        input  lookup_ack, lookup_hit, lookup_address, lookup_data,
        input  ctr_rd_ack, ctr_rd_data, miss_count
    );

    modport slave (
        input  lookup_req, lookup_cmp_data,
        input  wr_req, wr_addr, wr_valid, wr_cmp, wr_mask, wr_data,
        input  ctr_rd_req, ctr_rd_addr,
        output lookup_ack, lookup_hit, lookup_address, lookup_data,
        output ctr_rd_ack, ctr_rd_data, miss_count
    );
endinterface

// File: rtl/wildcard_flow_matcher.sv
// Wildcard flow table: NUM_ENTRIES ternary entries (key + don't-care mask),
// 2-cycle pipelined lookup with lowest-index priority, per-entry saturating
// hit counters with optional clear-on-read, and a saturating miss counter.
module wildcard_flow_matcher #(
    parameter int CMP_WIDTH     = 240,
    parameter int DATA_WIDTH    = 64,
    parameter int NUM_ENTRIES   = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int CNT_WIDTH     = 32,
    parameter bit CLEAR_ON_READ = 1'b1
) (
    input  logic clk,
    input  logic reset,
    wildcard_flow_matcher_if.slave bus
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // Table storage
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [CMP_WIDTH-1:0]   cmp_q  [NUM_ENTRIES];
    logic [CMP_WIDTH-1:0]   mask_q [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0]  act_q  [NUM_ENTRIES];
    logic [CNT_WIDTH-1:0]   hit_cnt_q [NUM_ENTRIES];
    logic [CNT_WIDTH-1:0]   miss_cnt_q;

    // Stage 1 registers: match vector plus a snapshot of the action that a
    // same-cycle write is about to overwrite, so stage 2 still reports the
    // action belonging to the entry state the match was taken against.
    logic                   s1_vld_q;
    logic [NUM_ENTRIES-1:0] match_q;
    logic                   haz_vld_q;
    logic [ADDR_WIDTH-1:0]  haz_addr_q;
    logic [DATA_WIDTH-1:0]  haz_act_q;

    // Stage 2 (output) registers
    logic                  ack_q;
    logic                  hit_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    // Counter read output registers
    logic                  rd_ack_q;
    logic [CNT_WIDTH-1:0]  rd_data_q;

    // Combinational helpers
    logic [NUM_ENTRIES-1:0] match_d;
    logic [NUM_ENTRIES-1:0] wr_sel, inc_sel, clr_sel;
    logic [DATA_WIDTH-1:0]  wr_old_act;
    logic                   win_hit;
    logic [ADDR_WIDTH-1:0]  win_addr;
    logic [DATA_WIDTH-1:0]  win_act;
    logic [CNT_WIDTH-1:0]   rd_val;

    // Per-entry decode of write, hit-increment and clear-on-read strobes;
    // out-of-range addresses simply select no entry.
    always_comb begin
        wr_sel  = '0;
        inc_sel = '0;
        clr_sel = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            wr_sel[i]  = bus.wr_req && (bus.wr_addr == ADDR_WIDTH'(i));
            inc_sel[i] = ack_q && hit_q && (addr_q == ADDR_WIDTH'(i));
            clr_sel[i] = CLEAR_ON_READ && bus.ctr_rd_req &&
                         (bus.ctr_rd_addr == ADDR_WIDTH'(i));
        end
    end

    // Ternary match of the incoming key against every entry (old table state)
    always_comb begin
        match_d    = '0;
        wr_old_act = '0;
        rd_val     = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            match_d[i] = valid_q[i] &&
                         (((bus.lookup_cmp_data ^ cmp_q[i]) & ~mask_q[i]) == '0);
            if (bus.wr_addr == ADDR_WIDTH'(i))
                wr_old_act = act_q[i];
            if (bus.ctr_rd_addr == ADDR_WIDTH'(i))
                rd_val = hit_cnt_q[i];
        end
    end

    // Lowest-index priority encode and action select for stage 2
    always_comb begin
        win_hit  = 1'b0;
        win_addr = '0;
        win_act  = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (match_q[i]) begin
                win_hit  = 1'b1;
                win_addr = ADDR_WIDTH'(i);
            end
        end
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (win_addr == ADDR_WIDTH'(i))
                win_act = act_q[i];
        end
        if (haz_vld_q && (haz_addr_q == win_addr))
            win_act = haz_act_q;
        if (!win_hit)
            win_act = '0;
    end

    // Key/mask/action storage; contents are don't-care until the valid bit is set
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (wr_sel[i]) begin
                cmp_q[i]  <= bus.wr_cmp;
                mask_q[i] <= bus.wr_mask;
                act_q[i]  <= bus.wr_data;
            end
        end
    end

    // Valid bits
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++)
                if (wr_sel[i]) valid_q[i] <= bus.wr_valid;
        end
    end

    // Lookup pipeline: stage 1 match capture, stage 2 result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld_q   <= 1'b0;
            match_q    <= '0;
            haz_vld_q  <= 1'b0;
            haz_addr_q <= '0;
            haz_act_q  <= '0;
            ack_q      <= 1'b0;
            hit_q      <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            s1_vld_q   <= bus.lookup_req;
            match_q    <= bus.lookup_req ? match_d : '0;
            haz_vld_q  <= bus.lookup_req && bus.wr_req;
            haz_addr_q <= bus.wr_addr;
            haz_act_q  <= wr_old_act;
            ack_q      <= s1_vld_q;
            hit_q      <= s1_vld_q && win_hit;
            addr_q     <= s1_vld_q ? win_addr : '0;
            data_q     <= s1_vld_q ? win_act : '0;
        end
    end

    // Hit counters: write clear beats everything, clear-on-read keeps a
    // same-cycle hit as 1, otherwise saturating increment on the ack cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) hit_cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (wr_sel[i])
                    hit_cnt_q[i] <= '0;
                else if (clr_sel[i])
                    hit_cnt_q[i] <= CNT_WIDTH'(inc_sel[i]);
                else if (inc_sel[i] && hit_cnt_q[i] != CNT_MAX)
                    hit_cnt_q[i] <= hit_cnt_q[i] + 1'b1;
            end
        end
    end

    // Saturating miss counter, counted on the ack cycle of a miss
    always_ff @(posedge clk) begin
        if (reset)
            miss_cnt_q <= '0;
        else if (ack_q && !hit_q && miss_cnt_q != CNT_MAX)
            miss_cnt_q <= miss_cnt_q + 1'b1;
    end

    // Counter read: returns the value at the start of the request cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_ack_q  <= bus.ctr_rd_req;
            rd_data_q <= bus.ctr_rd_req ? rd_val : '0;
        end
    end

    assign bus.lookup_ack     = ack_q;
    assign bus.lookup_hit     = hit_q;
    assign bus.lookup_address = addr_q;
    assign bus.lookup_data    = data_q;
    assign bus.ctr_rd_ack     = rd_ack_q;
    assign bus.ctr_rd_data    = rd_data_q;
    assign bus.miss_count     = miss_cnt_q;
endmodule
